// File: rtl/bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer: natural-order frames of 2^N samples in, bit-reversed (or natural) frames out.
// Latency: first output 2 cycles after a frame's last input sample; no back-pressure, and input rate never exceeds drain rate.
module bitrev_reorder #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_bypass,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_sop,
  output logic          out_eop
);

  localparam int DEPTH = 1 << N;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_t;

  logic [DW-1:0] mem_q [2][DEPTH];
  logic [1:0]    mode_q, mode_d;

  logic          wr_bank_q, wr_bank_d;
  logic [N-1:0]  wr_idx_q, wr_idx_d;

  rd_state_t     rd_state_q, rd_state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [N-1:0]  rd_idx_q, rd_idx_d;
  logic          rd_en;
  logic [N-1:0]  rd_addr;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;

  logic          full_evt;
  logic          rd_last;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] idx);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      r[k] = idx[N-1-k];
    end
    return r;
  endfunction

  assign full_evt = in_valid && (wr_idx_q == '1);
  assign rd_last  = (rd_idx_q == '1);
  assign rd_addr  = mode_q[rd_bank_q] ? rd_idx_q : bitrev(rd_idx_q);

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    mode_d    = mode_q;
    if (in_valid) begin
      wr_idx_d = wr_idx_q + 1'b1;
      // Mode is latched only at the first sample so mid-frame toggles are ignored.
      if (wr_idx_q == '0) begin
        mode_d[wr_bank_q] = in_bypass;
      end
      if (full_evt) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_idx_d   = rd_idx_q;
    rd_en      = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (full_evt) begin
          rd_state_d = RD_RUN;
          rd_bank_d  = wr_bank_q;
          rd_idx_d   = '0;
        end
      end
      RD_RUN: begin
        rd_en    = 1'b1;
        rd_idx_d = rd_idx_q + 1'b1;
        // A bank filling on the wrap cycle chains straight into the next drain.
        if (rd_last) begin
          if (full_evt) begin
            rd_bank_d = wr_bank_q;
          end else begin
            rd_state_d = RD_IDLE;
          end
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  always_comb begin
    out_valid_d = rd_en;
    out_data_d  = out_data_q;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    if (rd_en) begin
      out_data_d = mem_q[rd_bank_q][rd_addr];
      out_sop_d  = (rd_idx_q == '0);
      out_eop_d  = rd_last;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_q[wr_bank_q][wr_idx_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      mode_q      <= '0;
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      mode_q      <= mode_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;

endmodule
